// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - register file constants shared with the downstream read mux
package regfile_pkg;

    localparam int REG_WIDTH = 32;
    localparam int REG_DEPTH = 32;
    localparam int REG_AW    = 5;

    localparam logic [REG_AW-1:0] ZERO_REG = '0;

endpackage

// File: rtl/wr_decoder.sv
// rtl/wr_decoder.sv - address to one-hot enable decoder, register 0 never selected
module wr_decoder
    import regfile_pkg::*;
#(
    parameter int DEPTH = REG_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             en,
    input  logic [AW-1:0]    addr,
    output logic [DEPTH-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en && (addr != AW'(ZERO_REG))) begin
            onehot[addr] = 1'b1;
        end
        onehot[0] = 1'b0;
    end

endmodule

// File: rtl/reg_bank.sv
// rtl/reg_bank.sv - 32x32 register storage with destination-reservation scoreboard
module reg_bank
    import regfile_pkg::*;
#(
    parameter int WIDTH = REG_WIDTH,
    parameter int DEPTH = REG_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rsv_valid,
    input  logic [AW-1:0]          rsv_addr,
    output logic                   rsv_ready,
    output logic [DEPTH*WIDTH-1:0] regs_flat,
    output logic [DEPTH-1:0]       busy,
    output logic                   any_busy,
    output logic                   err_unrsv
);

    logic [DEPTH-1:0] wr_onehot;
    logic [DEPTH-1:0] rsv_onehot;
    logic             rsv_fire;
    logic [WIDTH-1:0] regs [1:DEPTH-1];

    // A write-back landing this cycle frees its slot for immediate re-reservation.
    assign rsv_ready = ~busy[rsv_addr] | (wr_en & (wr_addr == rsv_addr));
    assign rsv_fire  = rsv_valid & rsv_ready;
    assign any_busy  = |busy;

    wr_decoder #(.DEPTH(DEPTH), .AW(AW)) u_wr_dec (
        .en     (wr_en),
        .addr   (wr_addr),
        .onehot (wr_onehot)
    );

    wr_decoder #(.DEPTH(DEPTH), .AW(AW)) u_rsv_dec (
        .en     (rsv_fire),
        .addr   (rsv_addr),
        .onehot (rsv_onehot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (wr_onehot[i]) begin
                    regs[i] <= wr_data;
                end
            end
        end
    end

    // Clear before set: a same-cycle reservation of the written slot keeps it busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= ((busy & ~wr_onehot) | rsv_onehot) & ~DEPTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_unrsv <= 1'b0;
        end else if (|(wr_onehot & ~busy)) begin
            err_unrsv <= 1'b1;
        end
    end

    assign regs_flat[WIDTH-1:0] = '0;

    for (genvar g = 1; g < DEPTH; g++) begin : g_flat
        assign regs_flat[g*WIDTH +: WIDTH] = regs[g];
    end

endmodule

// File: tb/tb_reg_bank.sv
// tb/tb_reg_bank.sv - self-checking bench for reg_bank with a behavioural scoreboard model
module tb_reg_bank;

    logic          clk;
    logic          rst_n;
    logic          wr_en;
    logic [4:0]    wr_addr;
    logic [31:0]   wr_data;
    logic          rsv_valid;
    logic [4:0]    rsv_addr;
    logic          rsv_ready;
    logic [1023:0] regs_flat;
    logic [31:0]   busy;
    logic          any_busy;
    logic          err_unrsv;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_busy;
    logic        m_err;

    reg_bank dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .rsv_ready (rsv_ready),
        .regs_flat (regs_flat),
        .busy      (busy),
        .any_busy  (any_busy),
        .err_unrsv (err_unrsv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_busy = '0;
        m_err  = 1'b0;
    endtask

    function automatic logic model_ready();
        return !m_busy[rsv_addr] || (wr_en && (wr_addr == rsv_addr));
    endfunction

    function automatic logic [1023:0] model_flat();
        logic [1023:0] f;
        for (int i = 0; i < 32; i++) f[i*32 +: 32] = m_regs[i];
        return f;
    endfunction

    // One clock: the model applies the architectural rules using inputs held across the edge.
    task automatic step();
        logic rdy;
        rdy = model_ready();
        @(posedge clk);
        if (rst_n) begin
            if (wr_en && wr_addr != 5'd0) begin
                m_regs[wr_addr] = wr_data;
                if (!m_busy[wr_addr]) m_err = 1'b1;
                m_busy[wr_addr] = 1'b0;
            end
            if (rsv_valid && rdy && rsv_addr != 5'd0) m_busy[rsv_addr] = 1'b1;
        end
        #1;
    endtask

    task automatic idle();
        wr_en = 0; wr_addr = 0; wr_data = 0; rsv_valid = 0; rsv_addr = 0;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        model_reset();
        #3 rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        idle();
        wr_en = 1; wr_addr = 9; wr_data = 32'hABC;
        step();
        idle();
        rsv_valid = 1; rsv_addr = 2;
        step();
        idle();
        wr_en = 1; wr_addr = 4; wr_data = 32'h1;
        step();
        idle();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (regs_flat !== '0) begin errors++; $display("FAIL reset_regs got %h want 0", regs_flat[319:0]); end
        checks++; if (busy !== 32'h0) begin errors++; $display("FAIL reset_busy got %h want 00000000", busy); end
        checks++; if (any_busy !== 1'b0) begin errors++; $display("FAIL reset_any_busy got %b want 0", any_busy); end
        checks++; if (err_unrsv !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err_unrsv); end
        checks++; if (rsv_ready !== 1'b1) begin errors++; $display("FAIL reset_rsv_ready got %b want 1", rsv_ready); end
        #2 rst_n = 1'b1;
        step();
    endtask

    task automatic test_reserve_write();
        idle();
        rsv_valid = 1; rsv_addr = 5;
        checks++; if (rsv_ready !== 1'b1) begin errors++; $display("FAIL rsv5_ready got %b want 1", rsv_ready); end
        step();
        idle();
        checks++; if (busy !== 32'h0000_0020) begin errors++; $display("FAIL rsv5_busy got %h want 00000020", busy); end
        checks++; if (any_busy !== 1'b1) begin errors++; $display("FAIL rsv5_any_busy got %b want 1", any_busy); end
        rsv_valid = 1; rsv_addr = 5;
        #1;
        checks++; if (rsv_ready !== 1'b0) begin errors++; $display("FAIL rsv5_again_ready got %b want 0", rsv_ready); end
        step();
        idle();
        checks++; if (busy !== 32'h0000_0020) begin errors++; $display("FAIL rsv5_held_busy got %h want 00000020", busy); end
        wr_en = 1; wr_addr = 5; wr_data = 32'hDEAD_BEEF;
        step();
        idle();
        checks++; if (regs_flat[5*32 +: 32] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr5_data got %h want deadbeef", regs_flat[5*32 +: 32]); end
        checks++; if (busy !== 32'h0) begin errors++; $display("FAIL wr5_busy got %h want 00000000", busy); end
        checks++; if (err_unrsv !== 1'b0) begin errors++; $display("FAIL wr5_err got %b want 0", err_unrsv); end
    endtask

    task automatic test_zero_reg();
        idle();
        rsv_valid = 1; rsv_addr = 0;
        #1;
        checks++; if (rsv_ready !== 1'b1) begin errors++; $display("FAIL r0_ready got %b want 1", rsv_ready); end
        step();
        idle();
        checks++; if (busy !== 32'h0) begin errors++; $display("FAIL r0_busy got %h want 00000000", busy); end
        wr_en = 1; wr_addr = 0; wr_data = 32'hFFFF_FFFF;
        step();
        idle();
        checks++; if (regs_flat[31:0] !== 32'h0) begin errors++; $display("FAIL r0_data got %h want 00000000", regs_flat[31:0]); end
        checks++; if (err_unrsv !== 1'b0) begin errors++; $display("FAIL r0_err got %b want 0", err_unrsv); end
    endtask

    task automatic test_collision();
        idle();
        rsv_valid = 1; rsv_addr = 7;
        step();
        idle();
        wr_en = 1; wr_addr = 7; wr_data = 32'h1234;
        rsv_valid = 1; rsv_addr = 7;
        #1;
        checks++; if (rsv_ready !== 1'b1) begin errors++; $display("FAIL coll_ready got %b want 1", rsv_ready); end
        step();
        idle();
        checks++; if (regs_flat[7*32 +: 32] !== 32'h1234) begin errors++; $display("FAIL coll_data got %h want 00001234", regs_flat[7*32 +: 32]); end
        checks++; if (busy[7] !== 1'b1) begin errors++; $display("FAIL coll_busy7 got %b want 1", busy[7]); end
        checks++; if (err_unrsv !== 1'b0) begin errors++; $display("FAIL coll_err got %b want 0", err_unrsv); end
        wr_en = 1; wr_addr = 7; wr_data = 32'h0;
        rsv_valid = 1; rsv_addr = 9;
        step();
        idle();
        checks++; if (busy !== 32'h0000_0200) begin errors++; $display("FAIL split_busy got %h want 00000200", busy); end
        wr_en = 1; wr_addr = 9; wr_data = 32'h9;
        step();
        idle();
    endtask

    task automatic test_unrsv();
        idle();
        wr_en = 1; wr_addr = 3; wr_data = 32'h55;
        step();
        idle();
        checks++; if (regs_flat[3*32 +: 32] !== 32'h55) begin errors++; $display("FAIL unrsv_data got %h want 00000055", regs_flat[3*32 +: 32]); end
        checks++; if (err_unrsv !== 1'b1) begin errors++; $display("FAIL unrsv_err got %b want 1", err_unrsv); end
        repeat (5) step();
        checks++; if (err_unrsv !== 1'b1) begin errors++; $display("FAIL unrsv_sticky got %b want 1", err_unrsv); end
        do_reset();
        checks++; if (err_unrsv !== 1'b0) begin errors++; $display("FAIL unrsv_cleared got %b want 0", err_unrsv); end
    endtask

    task automatic test_sweep();
        idle();
        for (int a = 1; a < 32; a++) begin
            rsv_valid = 1; rsv_addr = 5'(a);
            step();
        end
        idle();
        checks++; if (busy !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sweep_busy_all got %h want fffffffe", busy); end
        checks++; if (any_busy !== 1'b1) begin errors++; $display("FAIL sweep_any_busy_set got %b want 1", any_busy); end
        for (int a = 1; a < 32; a++) begin
            wr_en = 1; wr_addr = 5'(a); wr_data = 32'(a);
            step();
        end
        idle();
        for (int a = 0; a < 32; a++) begin
            checks++;
            if (regs_flat[a*32 +: 32] !== 32'(a)) begin
                errors++; $display("FAIL sweep_reg%0d got %h want %h", a, regs_flat[a*32 +: 32], 32'(a));
            end
        end
        checks++; if (busy !== 32'h0) begin errors++; $display("FAIL sweep_busy_clear got %h want 00000000", busy); end
        checks++; if (any_busy !== 1'b0) begin errors++; $display("FAIL sweep_any_busy_clear got %b want 0", any_busy); end
        checks++; if (err_unrsv !== 1'b0) begin errors++; $display("FAIL sweep_err got %b want 0", err_unrsv); end
    endtask

    task automatic test_random();
        logic exp_rdy;
        for (int n = 0; n < 400; n++) begin
            wr_en     = ($urandom_range(0, 2) == 0);
            wr_addr   = 5'($urandom_range(0, 7));
            wr_data   = $urandom;
            rsv_valid = ($urandom_range(0, 1) == 1);
            rsv_addr  = 5'($urandom_range(0, 7));
            #1;
            exp_rdy = model_ready();
            checks++;
            if (rsv_ready !== exp_rdy) begin
                errors++; $display("FAIL rand_ready cycle %0d got %b want %b", n, rsv_ready, exp_rdy);
            end
            step();
            checks++;
            if (regs_flat !== model_flat()) begin
                errors++; $display("FAIL rand_regs cycle %0d got %h want %h", n, regs_flat[255:0], model_flat()[255:0]);
            end
            checks++;
            if (busy !== m_busy || any_busy !== (|m_busy)) begin
                errors++; $display("FAIL rand_busy cycle %0d got %h/%b want %h/%b", n, busy, any_busy, m_busy, |m_busy);
            end
            checks++;
            if (err_unrsv !== m_err) begin
                errors++; $display("FAIL rand_err cycle %0d got %b want %b", n, err_unrsv, m_err);
            end
        end
        idle();
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        test_reset();
        test_reserve_write();
        test_zero_reg();
        test_collision();
        test_unrsv();
        test_sweep();
        do_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
